// File: rtl/shape_pkg.sv
// Shared types for the shape bitmap reader: bitmap geometry, bitmap types and streamer states.
package shape_pkg;

  localparam int unsigned SHAPE_W = 25;
  localparam int unsigned SHAPE_H = 25;

  typedef logic [SHAPE_W-1:0] shape_row_t;
  typedef shape_row_t [0:SHAPE_H-1] shape_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } stream_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter: x advances on enable, wraps at X_LAST and carries into y.
// last flags the final coordinate of the frame.
module raster_counter #(
  parameter int unsigned CW     = 6,
  parameter int unsigned X_LAST = 24,
  parameter int unsigned Y_LAST = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == CW'(X_LAST));
  assign y_end = (y == CW'(Y_LAST));
  assign last  = x_end & y_end;

  // Coordinate registers; the final beat wraps both axes back to the origin.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shape_pixel_streamer.sv
// Captures one shape bitmap on start and serialises it as a raster-order valid/ready pixel
// stream. Optional build macro SHAPE_SCALE2_EN doubles both output dimensions so each
// bitmap bit is emitted as a 2x2 block.
module shape_pixel_streamer #(
  parameter int unsigned SHAPE_W        = shape_pkg::SHAPE_W,
  parameter int unsigned SHAPE_H        = shape_pkg::SHAPE_H,
  parameter bit          INK_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SHAPE_W-1:0] ishape [0:SHAPE_H-1],
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_ink,
  output logic [5:0]         pix_x,
  output logic [5:0]         pix_y,
  output logic               pix_last
);

  import shape_pkg::*;

`ifdef SHAPE_SCALE2_EN
  localparam int unsigned SCALE_SH = 1;
`else
  localparam int unsigned SCALE_SH = 0;
`endif

  localparam int unsigned OUT_W = SHAPE_W << SCALE_SH;
  localparam int unsigned OUT_H = SHAPE_H << SCALE_SH;
  localparam int unsigned XW    = $clog2(SHAPE_W);
  localparam int unsigned YW    = $clog2(SHAPE_H);

  stream_state_t      state_q, state_d;
  logic [SHAPE_W-1:0] shape_q [0:SHAPE_H-1];
  logic               cnt_clear;
  logic               cnt_en;
  logic               cnt_last;
  logic [5:0]         src_x;
  logic [5:0]         src_y;
  logic [XW-1:0]      col_idx;
  logic [YW-1:0]      row_idx;
  logic [SHAPE_W-1:0] row_bits;

  raster_counter #(
    .CW     (6),
    .X_LAST (OUT_W - 1),
    .Y_LAST (OUT_H - 1)
  ) u_raster_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .x     (pix_x),
    .y     (pix_y),
    .last  (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bitmap snapshot; later ishape changes cannot disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      shape_q <= '{default: '1};
    end else if (state_q == IDLE && start) begin
      shape_q <= ishape;
    end
  end

  // Next-state and counter control; start outside IDLE is dropped, not queued.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (pix_ready) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Source bit lookup from registered coordinates, so ink holds steady during a stall.
  always_comb begin
    src_x    = pix_x >> SCALE_SH;
    src_y    = pix_y >> SCALE_SH;
    col_idx  = XW'(6'(SHAPE_W - 1) - src_x);
    row_idx  = YW'(src_y);
    row_bits = shape_q[row_idx];
  end

  // Status and beat qualifiers; ink and last are masked outside STREAM.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    pix_valid = (state_q == STREAM);
    pix_last  = pix_valid & cnt_last;
    pix_ink   = pix_valid & (row_bits[col_idx] ^ INK_ACTIVE_LOW);
  end

endmodule
